// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the packet-aware stream multiplexer family.
package stream_mux_pkg;

  // Arbitration modes, used to give the RR parameter a readable meaning.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Index width for an n-way select; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int RR    = 1,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  localparam arb_mode_e MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

  // Walk the channels starting at the search origin and grant the first requester.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      if (MODE == ARB_RR) begin
        idx = (int'(ptr) + k) % N;
      end else begin
        idx = k;
      end
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with registered output, packet lock and round-robin/fixed arbitration.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int RR    = 1,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [WIDTH-1:0] in_data [N],
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             lock_reg;
  logic [SEL_W-1:0] lock_ch_reg;
  logic [SEL_W-1:0] ptr_reg;

  logic             load;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             xfer;
  logic             xfer_last;
  logic [SEL_W-1:0] ptr_next;

  // The output slot is free when empty or being drained this cycle.
  assign load = !out_valid_reg || out_ready;

  // While a packet is open only its owner may request; everyone else stalls.
  // The granted channel is only told ready when the output slot can take the beat.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign req[gi]      = in_valid[gi] && (!lock_reg || (lock_ch_reg == SEL_W'(gi)));
      assign in_ready[gi] = load && gnt[gi];
    end
  endgenerate

  rr_arbiter #(
    .N     (N),
    .RR    (RR),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign xfer      = load && any;
  assign xfer_last = in_last[gnt_idx];
  assign ptr_next  = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // Output register: capture on transfer, empty when the slot frees with nothing to load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_sel_reg   <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data[gnt_idx];
      out_last_reg  <= xfer_last;
      out_sel_reg   <= gnt_idx;
    end else if (load) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Packet lock and round-robin pointer follow each transferred beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_reg    <= 1'b0;
      lock_ch_reg <= '0;
      ptr_reg     <= '0;
    end else if (xfer) begin
      lock_reg    <= !xfer_last;
      lock_ch_reg <= gnt_idx;
      if (xfer_last) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one round-robin instance and one fixed-priority instance.
module tb_stream_mux_rr;

  logic       clk;
  logic       rst;

  // Round-robin instance signals
  logic [3:0] in_valid;
  logic [3:0] in_data [4];
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic [1:0] out_sel;
  logic       out_ready;

  // Fixed-priority instance signals
  logic [3:0] fp_in_valid;
  logic [3:0] fp_in_data [4];
  logic [3:0] fp_in_last;
  logic [3:0] fp_in_ready;
  logic       fp_out_valid;
  logic [3:0] fp_out_data;
  logic       fp_out_last;
  logic [1:0] fp_out_sel;
  logic       fp_out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  stream_mux_rr #(.WIDTH(4), .N(4), .RR(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.WIDTH(4), .N(4), .RR(0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fp_in_valid),
    .in_data   (fp_in_data),
    .in_last   (fp_in_last),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_last  (fp_out_last),
    .out_sel   (fp_out_sel),
    .out_ready (fp_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One log line per beat accepted by the consumer.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready)
      $display("[%0t] rr beat sel=%0d data=0x%h last=%0b", $time, out_sel, out_data, out_last);
    if (!rst && fp_out_valid && fp_out_ready)
      $display("[%0t] fp beat sel=%0d data=0x%h last=%0b", $time, fp_out_sel, fp_out_data, fp_out_last);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = '0; in_last = '0; out_ready = 1'b1;
    fp_in_valid = '0; fp_in_last = '0; fp_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data[i] = '0;
      fp_in_data[i] = '0;
    end
    tick(); tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 4'h0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++;
    if (out_sel !== 2'd0 || out_last !== 1'b0)
      $display("FAIL reset_sel_last got=%0d/%0b exp=0/0", out_sel, out_last); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got=%b exp=0000", in_ready); else pass_cnt++;
    rst = 1'b0;

    // Open a packet on ch2, then reset asynchronously in the middle of it.
    in_valid = 4'b0100; in_data[2] = 4'h5; in_last = 4'b0000;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL rst_pre_ready got=%b exp=0100", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd2)
      $display("FAIL rst_pre_beat got=v%0b d%h s%0d exp=v1 d5 s2", out_valid, out_data, out_sel); else pass_cnt++;
    in_valid = 4'b0001; in_data[0] = 4'h1; in_last = 4'b0001;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0000) $display("FAIL rst_locked_stall got=%b exp=0000", in_ready); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0 || out_last !== 1'b0)
      $display("FAIL rst_async_clear got=v%0b d%h s%0d l%0b exp=all0", out_valid, out_data, out_sel, out_last);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL rst_lock_cleared got=%b exp=0001", in_ready); else pass_cnt++;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111; in_last = 4'b1111;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL rst_ptr_cleared got=%b exp=0001", in_ready); else pass_cnt++;
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_fairness;
    logic [1:0] exp_sel;
    for (int i = 0; i < 4; i++) in_data[i] = 4'(8 + i);
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 2'(c % 4);
      total_cnt++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== 4'(8 + (c % 4)))
        $display("FAIL rr_seq[%0d] got=v%0b s%0d d%h exp=v1 s%0d d%h",
                 c, out_valid, out_sel, out_data, exp_sel, 4'(8 + (c % 4)));
      else pass_cnt++;
    end
    in_valid = 4'b0000;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rr_drain got=%0b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_packet_lock;
    // ptr is 0 here; ch2 alone starts its packet
    in_valid = 4'b0100; in_data[2] = 4'h1; in_last = 4'b0000;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL lock_b1_ready got=%b exp=0100", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_sel !== 2'd2 || out_data !== 4'h1 || out_last !== 1'b0)
      $display("FAIL lock_b1_out got=s%0d d%h l%0b exp=s2 d1 l0", out_sel, out_data, out_last); else pass_cnt++;
    in_valid = 4'b0101; in_data[0] = 4'hC; in_data[2] = 4'h2; in_last = 4'b0001;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL lock_b2_ready got=%b exp=0100", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_sel !== 2'd2 || out_data !== 4'h2)
      $display("FAIL lock_b2_out got=s%0d d%h exp=s2 d2", out_sel, out_data); else pass_cnt++;
    in_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      total_cnt++;
      if (in_ready !== 4'b0000) $display("FAIL lock_gap_ready[%0d] got=%b exp=0000", c, in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL lock_gap_valid[%0d] got=%0b exp=0", c, out_valid); else pass_cnt++;
    end
    in_valid = 4'b0101; in_data[2] = 4'h3; in_last = 4'b0101;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL lock_b3_ready got=%b exp=0100", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_sel !== 2'd2 || out_data !== 4'h3 || out_last !== 1'b1)
      $display("FAIL lock_b3_out got=s%0d d%h l%0b exp=s2 d3 l1", out_sel, out_data, out_last); else pass_cnt++;
    in_valid = 4'b0001;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL lock_release_ready got=%b exp=0001", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_sel !== 2'd0 || out_data !== 4'hC || out_valid !== 1'b1)
      $display("FAIL lock_next_out got=s%0d d%h v%0b exp=s0 dc v1", out_sel, out_data, out_valid); else pass_cnt++;
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure;
    // ptr is 1 after ch0's single-beat packet
    in_valid = 4'b0010; in_data[1] = 4'hA; in_last = 4'b1111; out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd1)
      $display("FAIL bp_load got=v%0b d%h s%0d exp=v1 da s1", out_valid, out_data, out_sel); else pass_cnt++;
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 4'(4 + i);
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd1)
        $display("FAIL bp_hold[%0d] got=v%0b d%h s%0d exp=v1 da s1", c, out_valid, out_data, out_sel);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h6)
      $display("FAIL bp_release_out got=v%0b s%0d d%h exp=v1 s2 d6", out_valid, out_sel, out_data); else pass_cnt++;
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_ptr_wrap;
    // ptr is 3; a single-beat packet from ch3 must wrap it to 0
    in_valid = 4'b1000; in_data[3] = 4'h7; in_last = 4'b1111;
    tick();
    total_cnt++;
    if (out_sel !== 2'd3 || out_data !== 4'h7)
      $display("FAIL wrap_ch3_out got=s%0d d%h exp=s3 d7", out_sel, out_data); else pass_cnt++;
    in_valid = 4'b1111; in_data[0] = 4'h9;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL wrap_ready got=%b exp=0001", in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_sel !== 2'd0 || out_data !== 4'h9 || out_valid !== 1'b1)
      $display("FAIL wrap_next_out got=s%0d d%h v%0b exp=s0 d9 v1", out_sel, out_data, out_valid); else pass_cnt++;
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fixed_priority;
    fp_in_valid = 4'b1010; fp_in_last = 4'b1111; fp_out_ready = 1'b1;
    fp_in_data[1] = 4'h1; fp_in_data[3] = 4'h3;
    for (int c = 0; c < 6; c++) begin
      #1;
      total_cnt++;
      if (fp_in_ready !== 4'b0010) $display("FAIL fp_ready[%0d] got=%b exp=0010", c, fp_in_ready); else pass_cnt++;
      tick();
      total_cnt++;
      if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 4'h1)
        $display("FAIL fp_out[%0d] got=v%0b s%0d d%h exp=v1 s1 d1", c, fp_out_valid, fp_out_sel, fp_out_data);
      else pass_cnt++;
    end
    fp_in_valid = 4'b1000;
    #1;
    total_cnt++;
    if (fp_in_ready !== 4'b1000) $display("FAIL fp_ch3_alone got=%b exp=1000", fp_in_ready); else pass_cnt++;
    tick();
    total_cnt++;
    if (fp_out_sel !== 2'd3 || fp_out_data !== 4'h3)
      $display("FAIL fp_ch3_out got=s%0d d%h exp=s3 d3", fp_out_sel, fp_out_data); else pass_cnt++;
    fp_in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_packet_lock();
    test_backpressure();
    test_ptr_wrap();
    test_fixed_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
